// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : pipe_hazard_ctrl
// Description: Stall/flush controller for the 5-stage pipeline: memory-miss
//              freeze FSM, load-use bubble and taken-branch IF/ID flush.
//              Optional macro PIPE_CTRL_PERF_EN builds stall/bubble counters.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_MemRead_i,
    input  logic [4:0]  ex_rt_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        branch_taken_i,
    input  logic        mem_access_i,
    input  logic        mem_hit_i,
    input  logic        mem_ack_i,
    output logic        mem_req_o,
    output logic        memStall_o,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        idex_bubble_o,
    output logic        ifid_flush_o,
    output logic        err_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] bubble_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            mem_req_q;
    logic            err_q;
    logic            w_miss;
    logic            w_hazard;

    assign w_miss   = mem_access_i & ~mem_hit_i;
    assign w_hazard = ex_MemRead_i & (ex_rt_i != 5'd0) &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_miss) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                end else if (cnt_q == C_TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_ERR;
        endcase
    end

    // Request and error flags track the next state so they are registered
    // outputs aligned with the state they describe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_req_q <= (state_d == S_REQ);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign mem_req_o  = mem_req_q;
    assign err_o      = err_q;
    assign memStall_o = ((state_q == S_IDLE) & w_miss) |
                        (state_q == S_REQ) | (state_q == S_ERR);

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        ifid_flush_o  = 1'b0;
        if (memStall_o) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (w_hazard) begin
            // Hazard beats branch: the branch re-resolves after the bubble.
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (memStall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (idex_bubble_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign bubble_cnt_o   = bubble_cnt_q;
`else
    assign stall_cycles_o = 32'd0;
    assign bubble_cnt_o   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_pipe_hazard_ctrl
// Description: Directed scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ex_MemRead_i = 1'b0;
    logic [4:0]  ex_rt_i = 5'd0;
    logic [4:0]  id_rs_i = 5'd0;
    logic [4:0]  id_rt_i = 5'd0;
    logic        branch_taken_i = 1'b0;
    logic        mem_access_i = 1'b0;
    logic        mem_hit_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic        mem_req_o;
    logic        memStall_o;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        idex_bubble_o;
    logic        ifid_flush_o;
    logic        err_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] bubble_cnt_o;

    pipe_hazard_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ex_MemRead_i   (ex_MemRead_i),
        .ex_rt_i        (ex_rt_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .branch_taken_i (branch_taken_i),
        .mem_access_i   (mem_access_i),
        .mem_hit_i      (mem_hit_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .memStall_o     (memStall_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .idex_bubble_o  (idex_bubble_o),
        .ifid_flush_o   (ifid_flush_o),
        .err_o          (err_o),
        .stall_cycles_o (stall_cycles_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ctrl = {memStall, mem_req, pc_write, ifid_write, bubble, flush, err}
    typedef struct {
        int          id;
        logic [6:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] bc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          step_id  = 0;
    logic [31:0] acc_sc   = 32'd0;
    logic [31:0] acc_bc   = 32'd0;

    localparam logic [6:0] N_RUN  = 7'b0011000;
    localparam logic [6:0] N_MISS = 7'b1000000;
    localparam logic [6:0] N_REQ  = 7'b1100000;
    localparam logic [6:0] N_BUB  = 7'b0000100;
    localparam logic [6:0] N_FLSH = 7'b0011010;
    localparam logic [6:0] N_ERR  = 7'b1000001;

    // One cycle of stimulus; inputs as {rst, access, hit, ack, exMR, br}.
    task automatic step(input logic [5:0] ctl, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [6:0] exp_ctrl);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = ctl[5];
        mem_access_i   = ctl[4];
        mem_hit_i      = ctl[3];
        mem_ack_i      = ctl[2];
        ex_MemRead_i   = ctl[1];
        branch_taken_i = ctl[0];
        ex_rt_i        = ert;
        id_rs_i        = rs;
        id_rt_i        = rt;
        if (!ctl[5]) begin
            acc_sc = 32'd0;
            acc_bc = 32'd0;
        end
        e.id   = step_id;
        e.ctrl = exp_ctrl;
`ifdef PIPE_CTRL_PERF_EN
        e.sc = acc_sc;
        e.bc = acc_bc;
        if (ctl[5] && exp_ctrl[6]) acc_sc = acc_sc + 32'd1;
        if (ctl[5] && exp_ctrl[2]) acc_bc = acc_bc + 32'd1;
`else
        e.sc = 32'd0;
        e.bc = 32'd0;
`endif
        sb_q.push_back(e);
        step_id++;
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [6:0] got;
            e   = sb_q.pop_front();
            got = {memStall_o, mem_req_o, pc_write_o, ifid_write_o,
                   idex_bubble_o, ifid_flush_o, err_o};
            n_checks++;
            if (got === e.ctrl && stall_cycles_o === e.sc && bubble_cnt_o === e.bc) begin
                n_pass++;
            end else begin
                $display("FAIL step%0d ctrl/perf got %b sc=%0d bc=%0d want %b sc=%0d bc=%0d",
                         e.id, got, stall_cycles_o, bubble_cnt_o, e.ctrl, e.sc, e.bc);
            end
        end
    end

    initial begin
        // reset state, then hit path
        step(6'b000000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b000000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b111000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b111000, 5'd0, 5'd0, 5'd0, N_RUN);
        // miss, ack in third REQ cycle, DONE ignores the lingering miss
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_MISS);
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b110100, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_RUN);
        // load-use on rs, release, r0 never hazards, hazard on rt
        step(6'b100010, 5'd5, 5'd5, 5'd0, N_BUB);
        step(6'b100000, 5'd5, 5'd5, 5'd0, N_RUN);
        step(6'b100010, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b100010, 5'd7, 5'd1, 5'd7, N_BUB);
        // hazard + branch: bubble only, then flush
        step(6'b100011, 5'd3, 5'd3, 5'd0, N_BUB);
        step(6'b100001, 5'd3, 5'd3, 5'd0, N_FLSH);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_RUN);
        // miss with hazard, ack in first REQ cycle, bubble lands in DONE
        step(6'b110010, 5'd4, 5'd0, 5'd4, N_MISS);
        step(6'b110110, 5'd4, 5'd0, 5'd4, N_REQ);
        step(6'b110010, 5'd4, 5'd0, 5'd4, N_BUB);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_RUN);
        // timeout after 4 REQ cycles, ERR ignores ack and branch
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_MISS);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_ERR);
        step(6'b100100, 5'd0, 5'd0, 5'd0, N_ERR);
        step(6'b100001, 5'd0, 5'd0, 5'd0, N_ERR);
        // reset asserted between edges clears ERR without a clock
        step(6'b000000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b000000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_RUN);
        step(6'b110000, 5'd0, 5'd0, 5'd0, N_MISS);
        step(6'b100100, 5'd0, 5'd0, 5'd0, N_REQ);
        step(6'b100000, 5'd0, 5'd0, 5'd0, N_RUN);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk_i);
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain scoreboard left %0d want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
